// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, keeps at most one IM request in flight and hands
// IPC-wide groups to Decode through an output register backed by one hold entry.
module instruction_fetch #(
    parameter int                       ADDRESS_WIDTH = 10,
    parameter int                       DATA_WIDTH    = 32,
    parameter int                       IPC           = 1,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fetch_en,
    input  logic                        redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0]    redirect_pc,
    output logic                        IM_req,
    output logic [ADDRESS_WIDTH-1:0]    IM_addr,
    input  logic [IPC*DATA_WIDTH-1:0]   IM_data,
    input  logic                        IM_dataValid,
    output logic [IPC*DATA_WIDTH-1:0]   DEC_data,
    output logic                        DEC_dataValid,
    input  logic                        DEC_ready,
    output logic [ADDRESS_WIDTH-1:0]    fetch_pc
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t                             state, state_nxt;
    logic [ADDRESS_WIDTH-1:0]           pc;
    logic [IPC-1:0][DATA_WIDTH-1:0]     hold_grp;
    logic [ADDRESS_WIDTH-1:0]           hold_pc;

    logic xfer, out_free, capture, load_out, load_hold, drain_hold;

    assign xfer       = DEC_dataValid & DEC_ready;
    assign out_free   = ~DEC_dataValid | DEC_ready;
    // A response racing a redirect is stale by definition and never captured.
    assign capture    = (state == S_WAIT) & IM_dataValid & ~redirect_valid;
    assign load_out   = capture & out_free;
    assign load_hold  = capture & ~out_free;
    assign drain_hold = (state == S_HOLD) & xfer & ~redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_REQ;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect_valid) begin
            // S_DROP doubles as the drop flag: the outstanding response must be swallowed.
            if ((state == S_WAIT || state == S_DROP) && !IM_dataValid) state_nxt = S_DROP;
            else                                                       state_nxt = S_REQ;
        end else begin
            case (state)
                S_REQ:   if (fetch_en)     state_nxt = S_WAIT;
                S_WAIT:  if (IM_dataValid) state_nxt = out_free ? S_REQ : S_HOLD;
                S_HOLD:  if (xfer)         state_nxt = S_REQ;
                S_DROP:  if (IM_dataValid) state_nxt = S_REQ;
                default:                   state_nxt = S_REQ;
            endcase
        end
    end

    always_comb begin
        IM_req  = 1'b0;
        IM_addr = '0;
        if (state == S_REQ && fetch_en && !redirect_valid) begin
            IM_req  = 1'b1;
            IM_addr = pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                pc <= RESET_PC;
        else if (redirect_valid) pc <= redirect_pc;
        else if (capture)        pc <= pc + ADDRESS_WIDTH'(IPC);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_grp <= '0;
            hold_pc  <= '0;
        end else if (load_hold) begin
            hold_grp <= IM_data;
            hold_pc  <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            DEC_data      <= '0;
            DEC_dataValid <= 1'b0;
            fetch_pc      <= '0;
        end else if (redirect_valid) begin
            DEC_dataValid <= 1'b0;
        end else if (load_out) begin
            DEC_data      <= IM_data;
            fetch_pc      <= pc;
            DEC_dataValid <= 1'b1;
        end else if (drain_hold) begin
            DEC_data      <= hold_grp;
            fetch_pc      <= hold_pc;
            DEC_dataValid <= 1'b1;
        end else if (xfer) begin
            DEC_dataValid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: behavioural IM models, directed scenarios and a
// randomized stream checked against an in-order PC/data scoreboard.
module tb_instruction_fetch;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b0, fetch_en = 1'b0, redirect_valid = 1'b0, DEC_ready = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          IM_req, DEC_dataValid;
    logic [AW-1:0] IM_addr, fetch_pc;
    logic [DW-1:0] IM_data = '0, DEC_data;
    logic          IM_dataValid = 1'b0;

    logic            b_fetch_en = 1'b0, b_redir = 1'b0, b_ready = 1'b1;
    logic [AW-1:0]   b_redir_pc = '0;
    logic            b_IM_req, b_DEC_dataValid;
    logic [AW-1:0]   b_IM_addr, b_fetch_pc;
    logic [2*DW-1:0] b_IM_data = '0, b_DEC_data;
    logic            b_IM_dataValid = 1'b0;

    int n_cmp = 0, n_err = 0;

    instruction_fetch #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .IPC(1), .RESET_PC(10'h010)) dut (
        .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .IM_req(IM_req), .IM_addr(IM_addr), .IM_data(IM_data),
        .IM_dataValid(IM_dataValid), .DEC_data(DEC_data), .DEC_dataValid(DEC_dataValid),
        .DEC_ready(DEC_ready), .fetch_pc(fetch_pc));

    instruction_fetch #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .IPC(2), .RESET_PC(10'h3FE)) dut2 (
        .clk(clk), .rst(rst), .fetch_en(b_fetch_en), .redirect_valid(b_redir),
        .redirect_pc(b_redir_pc), .IM_req(b_IM_req), .IM_addr(b_IM_addr), .IM_data(b_IM_data),
        .IM_dataValid(b_IM_dataValid), .DEC_data(b_DEC_data), .DEC_dataValid(b_DEC_dataValid),
        .DEC_ready(b_ready), .fetch_pc(b_fetch_pc));

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {6'h2A, a, 6'h15, a};
    endfunction

    // IM model: latency im_lat (or random 1..3), or fully manual via man_*.
    int            im_lat = 1, rem = 0, overlap = 0;
    logic          im_rand = 1'b0, im_manual = 1'b0, man_valid = 1'b0;
    logic [DW-1:0] man_data = '0;
    logic [AW-1:0] pend_addr = '0;
    logic [AW-1:0] req_q[$];

    always @(negedge clk) begin
        #2;
        IM_dataValid = 1'b0;
        if (!rst) rem = 0;
        if (im_manual) begin
            IM_dataValid = man_valid;
            IM_data      = man_data;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                IM_dataValid = 1'b1;
                IM_data      = mem_word(pend_addr);
            end
        end
        if (IM_req) begin
            if (rem > 0) overlap++;
            req_q.push_back(IM_addr);
            pend_addr = IM_addr;
            if (!im_manual) rem = im_rand ? int'($urandom_range(1, 3)) : im_lat;
        end
    end

    logic          b_pend = 1'b0;
    logic [AW-1:0] b_paddr = '0;
    logic [AW-1:0] b_req_q[$];

    always @(negedge clk) begin
        #2;
        b_IM_dataValid = b_pend && rst;
        b_IM_data      = {mem_word(b_paddr + 10'd1), mem_word(b_paddr)};
        b_pend         = b_IM_req;
        if (b_IM_req) begin
            b_paddr = b_IM_addr;
            b_req_q.push_back(b_IM_addr);
        end
    end

    task automatic idle_redirect(input logic [AW-1:0] pc);
        @(negedge clk);
        fetch_en = 1'b0; redirect_valid = 1'b1; redirect_pc = pc;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (IM_req !== 1'b0 || IM_addr !== '0 || DEC_dataValid !== 1'b0 ||
            DEC_data !== '0 || fetch_pc !== '0) begin
            n_err++;
            $display("FAIL reset_state: req=%b addr=%h vld=%b data=%h pc=%h, want all zero",
                     IM_req, IM_addr, DEC_dataValid, DEC_data, fetch_pc);
        end
        rst = 1'b1;
    endtask

    task automatic test_sequential();
        logic [AW-1:0] exp_pc = 10'h010;
        int got = 0;
        req_q.delete(); im_lat = 1; DEC_ready = 1'b1; fetch_en = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 7) fetch_en = 1'b0;
            if (DEC_dataValid && DEC_ready) begin
                n_cmp++;
                if (fetch_pc !== exp_pc || DEC_data !== mem_word(exp_pc)) begin
                    n_err++;
                    $display("FAIL seq_group: pc=%h data=%h, want pc=%h data=%h",
                             fetch_pc, DEC_data, exp_pc, mem_word(exp_pc));
                end
                exp_pc++; got++;
            end
        end
        n_cmp++;
        if (req_q.size() < 3 || req_q[0] !== 10'h010 || req_q[1] !== 10'h011 || req_q[2] !== 10'h012) begin
            n_err++;
            $display("FAIL seq_addr: %0d reqs first=%h, want 010,011,012",
                     req_q.size(), (req_q.size() > 0) ? req_q[0] : 10'h0);
        end
        n_cmp++;
        if (got !== req_q.size()) begin
            n_err++;
            $display("FAIL seq_count: delivered %0d, want %0d", got, req_q.size());
        end
    endtask

    task automatic test_backpressure();
        idle_redirect(10'h040);
        req_q.delete(); im_lat = 1; DEC_ready = 1'b0; fetch_en = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                n_cmp++;
                if (DEC_dataValid !== 1'b1 || fetch_pc !== 10'h040 || DEC_data !== mem_word(10'h040)) begin
                    n_err++;
                    $display("FAIL stall_stable: vld=%b pc=%h data=%h, want 1 040 %h",
                             DEC_dataValid, fetch_pc, DEC_data, mem_word(10'h040));
                end
            end
        end
        n_cmp++;
        if (IM_req !== 1'b0 || req_q.size() !== 2 || req_q[0] !== 10'h040 || req_q[1] !== 10'h041) begin
            n_err++;
            $display("FAIL hold_no_req: IM_req=%b reqs=%0d, want 0 and 2", IM_req, req_q.size());
        end
        DEC_ready = 1'b1; fetch_en = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (DEC_dataValid !== 1'b1 || fetch_pc !== 10'h041 || DEC_data !== mem_word(10'h041)) begin
            n_err++;
            $display("FAIL drain_second: vld=%b pc=%h data=%h, want 1 041 %h",
                     DEC_dataValid, fetch_pc, DEC_data, mem_word(10'h041));
        end
        @(negedge clk);
        n_cmp++;
        if (DEC_dataValid !== 1'b0 || req_q.size() !== 2) begin
            n_err++;
            $display("FAIL drain_empty: vld=%b reqs=%0d, want 0 and 2", DEC_dataValid, req_q.size());
        end
    endtask

    task automatic test_redirect_hold();
        int seen = 0, got = 0;
        idle_redirect(10'h0A0);
        im_lat = 1; DEC_ready = 1'b0; fetch_en = 1'b1;
        repeat (4) @(negedge clk);
        fetch_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 10'h150;
        @(negedge clk);
        redirect_valid = 1'b0; DEC_ready = 1'b1;
        n_cmp++;
        if (DEC_dataValid !== 1'b0) begin
            n_err++;
            $display("FAIL hold_flush_out: vld=%b, want 0", DEC_dataValid);
        end
        repeat (4) begin
            @(negedge clk);
            if (DEC_dataValid) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL hold_cleared: %0d stale groups, want 0", seen);
        end
        fetch_en = 1'b1;
        #1;
        n_cmp++;
        if (IM_req !== 1'b1 || IM_addr !== 10'h150) begin
            n_err++;
            $display("FAIL hold_redir_req: req=%b addr=%h, want 1 150", IM_req, IM_addr);
        end
        @(negedge clk);
        fetch_en = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (DEC_dataValid && DEC_ready) begin
                got++;
                n_cmp++;
                if (fetch_pc !== 10'h150 || DEC_data !== mem_word(10'h150)) begin
                    n_err++;
                    $display("FAIL hold_redir_grp: pc=%h, want 150", fetch_pc);
                end
            end
        end
        n_cmp++;
        if (got !== 1) begin
            n_err++;
            $display("FAIL hold_redir_cnt: %0d groups, want 1", got);
        end
    endtask

    task automatic test_redirect_wait();
        idle_redirect(10'h013);
        im_manual = 1'b1; man_valid = 1'b0; DEC_ready = 1'b1; fetch_en = 1'b1;
        #1;
        n_cmp++;
        if (IM_req !== 1'b1 || IM_addr !== 10'h013) begin
            n_err++;
            $display("FAIL req_013: req=%b addr=%h, want 1 013", IM_req, IM_addr);
        end
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 10'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        n_cmp++;
        if (IM_req !== 1'b0) begin
            n_err++;
            $display("FAIL drop_no_req: req=%b, want 0", IM_req);
        end
        @(negedge clk);
        man_valid = 1'b1; man_data = mem_word(10'h013);
        @(negedge clk);
        man_valid = 1'b0;
        #1;
        n_cmp++;
        if (IM_req !== 1'b1 || IM_addr !== 10'h200 || DEC_dataValid !== 1'b0) begin
            n_err++;
            $display("FAIL stale_dropped: req=%b addr=%h vld=%b, want 1 200 0",
                     IM_req, IM_addr, DEC_dataValid);
        end
        @(negedge clk);
        fetch_en = 1'b0; man_valid = 1'b1; man_data = mem_word(10'h200);
        @(negedge clk);
        man_valid = 1'b0;
        n_cmp++;
        if (DEC_dataValid !== 1'b1 || fetch_pc !== 10'h200 || DEC_data !== mem_word(10'h200)) begin
            n_err++;
            $display("FAIL redir_group: vld=%b pc=%h data=%h, want 1 200 %h",
                     DEC_dataValid, fetch_pc, DEC_data, mem_word(10'h200));
        end
        im_manual = 1'b0;
    endtask

    task automatic test_redirect_resp();
        idle_redirect(10'h080);
        im_manual = 1'b1; man_valid = 1'b0; DEC_ready = 1'b0; fetch_en = 1'b1;
        @(negedge clk);
        man_valid = 1'b1; man_data = mem_word(10'h080);
        @(negedge clk);
        man_valid = 1'b0;
        #1;
        n_cmp++;
        if (DEC_dataValid !== 1'b1 || fetch_pc !== 10'h080 || IM_req !== 1'b1 || IM_addr !== 10'h081) begin
            n_err++;
            $display("FAIL full_setup: vld=%b pc=%h req=%b addr=%h, want 1 080 1 081",
                     DEC_dataValid, fetch_pc, IM_req, IM_addr);
        end
        @(negedge clk);
        fetch_en = 1'b0; man_valid = 1'b1; man_data = mem_word(10'h081);
        redirect_valid = 1'b1; redirect_pc = 10'h300;
        @(negedge clk);
        redirect_valid = 1'b0; man_valid = 1'b0;
        n_cmp++;
        if (DEC_dataValid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_out: vld=%b, want 0", DEC_dataValid);
        end
        fetch_en = 1'b1;
        #1;
        n_cmp++;
        if (IM_req !== 1'b1 || IM_addr !== 10'h300) begin
            n_err++;
            $display("FAIL req_after_flush: req=%b addr=%h, want 1 300", IM_req, IM_addr);
        end
        @(negedge clk);
        fetch_en = 1'b0; man_valid = 1'b1; man_data = mem_word(10'h300); DEC_ready = 1'b1;
        @(negedge clk);
        man_valid = 1'b0;
        n_cmp++;
        if (DEC_dataValid !== 1'b1 || fetch_pc !== 10'h300 || DEC_data !== mem_word(10'h300)) begin
            n_err++;
            $display("FAIL flush_next: vld=%b pc=%h, want 1 300", DEC_dataValid, fetch_pc);
        end
        @(negedge clk);
        n_cmp++;
        if (DEC_dataValid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_drain: vld=%b, want 0", DEC_dataValid);
        end
        im_manual = 1'b0;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_pc = 10'h3FF;
        int b_got = 0;
        idle_redirect(10'h3FF);
        req_q.delete(); b_req_q.delete(); im_lat = 1; DEC_ready = 1'b1;
        fetch_en = 1'b1; b_fetch_en = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 3) begin fetch_en = 1'b0; b_fetch_en = 1'b0; end
            if (DEC_dataValid) begin
                n_cmp++;
                if (fetch_pc !== exp_pc || DEC_data !== mem_word(exp_pc)) begin
                    n_err++;
                    $display("FAIL wrap_group: pc=%h, want %h", fetch_pc, exp_pc);
                end
                exp_pc++;
            end
            if (b_DEC_dataValid && b_got == 0) begin
                b_got++;
                n_cmp++;
                if (b_fetch_pc !== 10'h3FE || b_DEC_data !== {mem_word(10'h3FF), mem_word(10'h3FE)}) begin
                    n_err++;
                    $display("FAIL ipc2_group: pc=%h data=%h, want 3fe %h%h", b_fetch_pc, b_DEC_data,
                             mem_word(10'h3FF), mem_word(10'h3FE));
                end
            end
        end
        n_cmp++;
        if (req_q.size() !== 2 || req_q[0] !== 10'h3FF || req_q[1] !== 10'h000) begin
            n_err++;
            $display("FAIL wrap_ipc1: %0d reqs second=%h, want 2 reqs 3ff,000",
                     req_q.size(), (req_q.size() > 1) ? req_q[1] : 10'h0);
        end
        n_cmp++;
        if (b_req_q.size() !== 2 || b_req_q[0] !== 10'h3FE || b_req_q[1] !== 10'h000) begin
            n_err++;
            $display("FAIL wrap_ipc2: %0d reqs second=%h, want 2 reqs 3fe,000",
                     b_req_q.size(), (b_req_q.size() > 1) ? b_req_q[1] : 10'h0);
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] start, exp_pc, held_pc;
        logic [DW-1:0] held_d = '0;
        logic          stalled = 1'b0;
        int got = 0, bad = 0;
        start = AW'($urandom);
        idle_redirect(start);
        req_q.delete(); overlap = 0; im_rand = 1'b1; exp_pc = start; held_pc = start;
        for (int c = 0; c < 260; c++) begin
            @(negedge clk);
            fetch_en  = (c < 230) && ($urandom_range(0, 9) < 7);
            DEC_ready = (c >= 230) || ($urandom_range(0, 9) < 5);
            if (stalled) begin
                n_cmp++;
                if (DEC_dataValid !== 1'b1 || DEC_data !== held_d || fetch_pc !== held_pc) begin
                    n_err++;
                    $display("FAIL rnd_stable: vld=%b pc=%h, want 1 %h", DEC_dataValid, fetch_pc, held_pc);
                end
            end
            if (DEC_dataValid && DEC_ready) begin
                n_cmp++;
                if (fetch_pc !== exp_pc || DEC_data !== mem_word(exp_pc)) begin
                    n_err++;
                    $display("FAIL rnd_group: pc=%h data=%h, want pc=%h data=%h",
                             fetch_pc, DEC_data, exp_pc, mem_word(exp_pc));
                end
                exp_pc++; got++;
            end
            stalled = DEC_dataValid && !DEC_ready;
            held_d  = DEC_data;
            held_pc = fetch_pc;
        end
        im_rand = 1'b0;
        for (int i = 0; i < req_q.size(); i++)
            if (req_q[i] !== start + AW'(i)) bad++;
        n_cmp++;
        if (bad !== 0 || overlap !== 0) begin
            n_err++;
            $display("FAIL rnd_reqs: %0d out-of-order, %0d overlapping, want 0 0", bad, overlap);
        end
        n_cmp++;
        if (got !== req_q.size() || got < 10) begin
            n_err++;
            $display("FAIL rnd_count: delivered %0d of %0d requests", got, req_q.size());
        end
    endtask

    task automatic test_async_reset();
        int got = 0;
        idle_redirect(10'h050);
        im_lat = 3; DEC_ready = 1'b0; fetch_en = 1'b1;
        repeat (5) @(negedge clk);
        fetch_en = 1'b0;
        n_cmp++;
        if (DEC_dataValid !== 1'b1 || fetch_pc !== 10'h050) begin
            n_err++;
            $display("FAIL rst_setup: vld=%b pc=%h, want 1 050", DEC_dataValid, fetch_pc);
        end
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if (IM_req !== 1'b0 || IM_addr !== '0 || DEC_dataValid !== 1'b0 ||
            DEC_data !== '0 || fetch_pc !== '0) begin
            n_err++;
            $display("FAIL async_reset: req=%b addr=%h vld=%b data=%h pc=%h, want all zero",
                     IM_req, IM_addr, DEC_dataValid, DEC_data, fetch_pc);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1; im_lat = 1; DEC_ready = 1'b1; fetch_en = 1'b1;
        #1;
        n_cmp++;
        if (IM_req !== 1'b1 || IM_addr !== 10'h010) begin
            n_err++;
            $display("FAIL post_reset_req: req=%b addr=%h, want 1 010", IM_req, IM_addr);
        end
        @(negedge clk);
        fetch_en = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (DEC_dataValid && got == 0) begin
                got++;
                n_cmp++;
                if (fetch_pc !== 10'h010 || DEC_data !== mem_word(10'h010)) begin
                    n_err++;
                    $display("FAIL post_reset_grp: pc=%h, want 010", fetch_pc);
                end
            end
        end
        n_cmp++;
        if (got !== 1) begin
            n_err++;
            $display("FAIL post_reset_cnt: %0d groups, want 1", got);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_hold();
        test_redirect_wait();
        test_redirect_resp();
        test_wrap();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
